weight_stream_bram: RTL and testbench
=====================================

WEIGHT_STREAM_BRAM -- requirements
Module: weight_stream_bram

Interface
REQ-001 Parameter DATA_W, default 16, weight word width in bits.
REQ-002 Parameter DEPTH, default 28, number of weight words stored.
REQ-003 Parameter ADDR_W, default 5, address width, SHALL satisfy 2^ADDR_W >= DEPTH.
REQ-004 Parameter LEN_W, default 6, burst length field width.
REQ-005 Parameter INIT_FILE, default "weight_0_0_0.txt", binary image loaded into memory at elaboration.
REQ-006 CLK  in  1  single clock; all logic on rising edge.
REQ-007 RST_N  in  1  asynchronous, active-low reset.
REQ-008 WE  in  1  write strobe; WADDR  in  ADDR_W  write address; DI  in  DATA_W  write data.
REQ-009 START  in  1  burst request; BASE  in  ADDR_W  first read address; LEN  in  LEN_W  word count.
REQ-010 BUSY  out  1  burst in progress; DONE  out  1  one-cycle burst-complete pulse; ERR  out  1  one-cycle rejected-request pulse.
REQ-011 DO  out  DATA_W  streamed weight; DO_VALID  out  1  DO valid; DO_READY  in  1  downstream accepts DO.

Function
REQ-012 Memory SHALL be DEPTH x DATA_W block RAM, read-first, one-cycle registered read, initialised from INIT_FILE via binary load.
REQ-013 WE high with WADDR < DEPTH SHALL write DI at that edge; WADDR >= DEPTH SHALL be ignored; writes accepted in any state.
REQ-014 Same-edge write and read to one address SHALL return the old word.
REQ-015 FSM states IDLE, RUN, DRAIN; reset state IDLE.
REQ-016 IDLE: START with LEN = 0 and BASE < DEPTH SHALL pulse DONE next cycle and stay IDLE.
REQ-017 IDLE: valid START with LEN > 0 SHALL latch pointer = BASE, remaining = LEN, enter RUN, assert BUSY next cycle.
REQ-018 START while BUSY SHALL be ignored (no ERR, no effect).
REQ-019 RUN: a read SHALL issue when occupancy + in_flight - pop < 2 (pop = DO_VALID and DO_READY); each issue increments pointer, decrements remaining.
REQ-020 remaining reaching 0 SHALL move RUN -> DRAIN.
REQ-021 DRAIN: buffer empty and nothing in flight SHALL move to IDLE, clear BUSY and pulse DONE on the same edge.
REQ-022 Output SHALL be a 2-entry FIFO; DO_VALID = non-empty; DO = head; DO and DO_VALID stable while DO_VALID and not DO_READY.
REQ-023 Latency: START sampled at edge k -> first read edge k+1 -> DO_VALID after edge k+2; DO_READY held high SHALL yield one word per cycle with no bubbles.
REQ-024 Words SHALL be emitted in address order BASE, BASE+1, ...; no word dropped or duplicated under any DO_READY pattern.
REQ-025 BASE >= DEPTH SHALL pulse ERR next cycle and start no burst.

Reset
REQ-026 RST_N low SHALL immediately force IDLE, empty FIFO, discard in-flight read, DO = 0, DO_VALID = 0, BUSY = 0, DONE = 0, ERR = 0.
REQ-027 Reset SHALL NOT alter memory contents; reset mid-burst aborts it with no DONE.
REQ-028 First START accepted on the first rising edge after RST_N rises.

Configuration
REQ-029 Macro WEIGHT_STREAM_WRAP_EN SHALL select address wrap behaviour.
REQ-030 Defined: pointer SHALL wrap DEPTH-1 -> 0; any LEN accepted (words repeat if LEN > DEPTH).
REQ-031 Undefined: START with BASE + LEN > DEPTH SHALL pulse ERR next cycle and start no burst.

Verification
REQ-032 Reset, START BASE=0 LEN=28, DO_READY=1 -> 28 words equal file image, DO_VALID continuous edges 2..29 after START, DONE one cycle after last transfer.
REQ-033 START BASE=4 LEN=6, DO_READY toggled 1/0 each cycle -> words 4..9 in order, DO stable during stalls, FIFO never overflows.
REQ-034 WE WADDR=7 DI=16'hA5A5 then START BASE=7 LEN=1 -> DO=16'hA5A5; same-edge write/read of addr 7 returns prior value.
REQ-035 START BASE=25 LEN=6: WRAP_EN undefined -> ERR pulse, BUSY stays 0; defined -> words 25,26,27,0,1,2 then DONE.
REQ-036 RST_N pulled low at 3rd word of LEN=10 burst -> DO_VALID, BUSY 0 immediately, no DONE; new START BASE=0 LEN=2 then streams words 0,1.

Source files
------------

// File: rtl/weight_stream_bram.sv
`default_nettype none
// ============================================================================
// weight_stream_bram : weight block RAM streamed out as bursts via a 2-entry FIFO
// Optional macro WEIGHT_STREAM_WRAP_EN : read pointer wraps DEPTH-1 -> 0
// Rev 1.0
// ============================================================================
module weight_stream_bram #(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 28,
  parameter int ADDR_W    = 5,
  parameter int LEN_W     = 6,
  parameter     INIT_FILE = "weight_0_0_0.txt"
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              WE,
  input  logic [ADDR_W-1:0] WADDR,
  input  logic [DATA_W-1:0] DI,
  input  logic              START,
  input  logic [ADDR_W-1:0] BASE,
  input  logic [LEN_W-1:0]  LEN,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic [DATA_W-1:0] DO,
  output logic              DO_VALID,
  input  logic              DO_READY
);

  localparam logic [ADDR_W:0]   c_depth = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] c_last  = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  (* ram_init_file = INIT_FILE *) logic [DATA_W-1:0] r_mem [0:DEPTH-1];
  logic [DATA_W-1:0] r_rd_data;
  logic [DATA_W-1:0] r_fifo [0:1];

  state_t            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [LEN_W-1:0]  r_remaining;
  logic              r_inflight;
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic              w_pop;
  logic              w_room;
  logic              w_issue;
  logic              w_bad;
  logic              w_waddr_ok;
  logic [ADDR_W-1:0] w_ptr_next;

  assign w_pop      = DO_VALID && DO_READY;
  assign w_waddr_ok = ({1'b0, WADDR} < c_depth);
  // Never let buffered + outstanding words exceed the two FIFO slots.
  assign w_room     = (({1'b0, r_count} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop}));
  assign w_issue    = (r_state == S_RUN) && (r_remaining != '0) && w_room;

`ifdef WEIGHT_STREAM_WRAP_EN
  assign w_ptr_next = (r_ptr == c_last) ? '0 : r_ptr + 1'b1;
  assign w_bad      = ({1'b0, BASE} >= c_depth);
`else
  localparam int c_sum_w = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 1;
  localparam logic [c_sum_w-1:0] c_depth_sum = c_sum_w'(DEPTH);
  logic [c_sum_w-1:0] w_end;

  assign w_end      = c_sum_w'(BASE) + c_sum_w'(LEN);
  assign w_ptr_next = r_ptr + 1'b1;
  assign w_bad      = ({1'b0, BASE} >= c_depth) || (w_end > c_depth_sum);
`endif

  assign BUSY     = r_busy;
  assign DONE     = r_done;
  assign ERR      = r_err;
  assign DO_VALID = (r_count != 2'd0);
  assign DO       = r_fifo[r_rd_ptr];

  // Memory is never reset; nonblocking update gives read-first on collisions.
  always_ff @(posedge CLK) begin
    if (WE && w_waddr_ok) begin
      r_mem[WADDR] <= DI;
    end
    if (w_issue) begin
      r_rd_data <= r_mem[r_ptr];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_remaining <= '0;
      r_inflight  <= 1'b0;
      r_fifo[0]   <= '0;
      r_fifo[1]   <= '0;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_count     <= 2'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_inflight <= w_issue;

      if (r_inflight) begin
        r_fifo[r_wr_ptr] <= r_rd_data;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};

      case (r_state)
        S_IDLE: begin
          if (START) begin
            if (w_bad) begin
              r_err <= 1'b1;
            end else if (LEN == '0) begin
              r_done <= 1'b1;
            end else begin
              r_ptr       <= BASE;
              r_remaining <= LEN;
              r_busy      <= 1'b1;
              r_state     <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (w_issue) begin
            r_ptr       <= w_ptr_next;
            r_remaining <= r_remaining - 1'b1;
            if (r_remaining == LEN_W'(1)) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if ((r_count == 2'd0) && !r_inflight) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_weight_stream_bram.sv
`default_nettype none
// ============================================================================
// tb_weight_stream_bram : randomized burst checks against an array/queue model
// Rev 1.0
// ============================================================================
module tb_weight_stream_bram;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 28;
  localparam int ADDR_W = 5;
  localparam int LEN_W  = 6;
`ifdef WEIGHT_STREAM_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              RST_N = 1'b0;
  logic              WE = 1'b0;
  logic [ADDR_W-1:0] WADDR = '0;
  logic [DATA_W-1:0] DI = '0;
  logic              START = 1'b0;
  logic [ADDR_W-1:0] BASE = '0;
  logic [LEN_W-1:0]  LEN = '0;
  logic              BUSY;
  logic              DONE;
  logic              ERR;
  logic [DATA_W-1:0] DO;
  logic              DO_VALID;
  logic              DO_READY = 1'b0;

  logic [DATA_W-1:0] mem_model [0:DEPTH-1];
  int n_pass  = 0;
  int n_total = 0;

  weight_stream_bram #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .LEN_W(LEN_W),
    .INIT_FILE("weight_0_0_0.txt")
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .WE(WE), .WADDR(WADDR), .DI(DI),
    .START(START), .BASE(BASE), .LEN(LEN), .BUSY(BUSY), .DONE(DONE),
    .ERR(ERR), .DO(DO), .DO_VALID(DO_VALID), .DO_READY(DO_READY)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic write_word(input int addr, input logic [DATA_W-1:0] data);
    @(negedge CLK);
    WE = 1'b1; WADDR = addr[ADDR_W-1:0]; DI = data;
    @(negedge CLK);
    WE = 1'b0;
    if (addr < DEPTH) mem_model[addr] = data;
  endtask

  // mode 0: ready always high, 1: toggling, 2: random
  task automatic run_burst(input int base, input int len, input int mode,
                           input bit do_wr, input int wa, input logic [DATA_W-1:0] wd);
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] prev_do;
    bit   bad, rdy, prev_stall;
    int   got, first_c, last_c, err_seen, c;
    bad = (base >= DEPTH) || (!WRAP && (base + len > DEPTH));
    if (!bad) for (int i = 0; i < len; i++) exp_q.push_back(mem_model[(base + i) % DEPTH]);
    if (do_wr && wa < DEPTH) mem_model[wa] = wd;
    @(negedge CLK);
    START = 1'b1; BASE = base[ADDR_W-1:0]; LEN = len[LEN_W-1:0];
    @(posedge CLK);
    #1;
    START = 1'b0;
    if (do_wr) begin WE = 1'b1; WADDR = wa[ADDR_W-1:0]; DI = wd; end
    if (bad || len == 0) begin
      @(negedge CLK);
      WE = 1'b0;
      check_eq("req_err", ERR, bad);
      check_eq("req_done", DONE, !bad);
      check_eq("req_busy", BUSY, 0);
      @(negedge CLK);
      check_eq("pulse_one_cycle", {ERR, DONE}, 0);
      check_eq("idle_valid", DO_VALID, 0);
      return;
    end
    got = 0; first_c = -1; last_c = -1; err_seen = 0; prev_stall = 1'b0; prev_do = '0;
    for (c = 0; c < 400; c++) begin
      @(negedge CLK);
      if (c == 1) WE = 1'b0;
      if (c == 0) check_eq("busy_next", BUSY, 1);
      if (ERR) err_seen++;
      if (DONE) break;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (c % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      DO_READY = rdy;
      START = BUSY && ($urandom_range(0, 3) == 0);
      BASE  = ADDR_W'($urandom);
      LEN   = LEN_W'($urandom);
      if (prev_stall) begin
        check_eq("hold_valid", DO_VALID, 1);
        check_eq("hold_data", DO, prev_do);
      end
      if (DO_VALID && first_c < 0) first_c = c;
      if (DO_VALID && rdy) begin
        if (exp_q.size() == 0) check_eq("extra_word", 1, 0);
        else check_eq("word", DO, exp_q.pop_front());
        got++;
        last_c = c;
      end
      prev_stall = DO_VALID && !rdy;
      prev_do    = DO;
    end
    START = 1'b0; WE = 1'b0;
    if (c >= 400) check_eq("timeout", 0, 1);
    check_eq("word_count", got, len);
    check_eq("done_gap", c - last_c, 2);
    check_eq("busy_clear", BUSY, 0);
    check_eq("no_err_busy", err_seen, 0);
    if (mode == 0) begin
      check_eq("first_latency", first_c, 2);
      check_eq("no_bubble", last_c - first_c, len - 1);
    end
  endtask

  initial begin
    int n, b, l, m;
    repeat (3) @(posedge CLK);
    #1;
    check_eq("rst_valid", DO_VALID, 0);
    check_eq("rst_busy", BUSY, 0);
    check_eq("rst_done", DONE, 0);
    check_eq("rst_err", ERR, 0);
    check_eq("rst_do", DO, 0);
    @(negedge CLK);
    RST_N = 1'b1;

    for (int a = 0; a < 32; a++) write_word(a, DATA_W'($urandom));

    run_burst(0, DEPTH, 0, 1'b0, 0, '0);
    run_burst(4, 6, 1, 1'b0, 0, '0);
    write_word(7, 16'hA5A5);
    run_burst(7, 1, 0, 1'b0, 0, '0);
    run_burst(7, 1, 0, 1'b1, 7, 16'h1234);
    run_burst(7, 1, 0, 1'b0, 0, '0);
    run_burst(25, 6, 0, 1'b0, 0, '0);
    run_burst(3, 0, 0, 1'b0, 0, '0);
    run_burst(28, 1, 0, 1'b0, 0, '0);
    run_burst(30, 0, 0, 1'b0, 0, '0);

    for (int k = 0; k < 24; k++) begin
      write_word($urandom_range(0, 31), DATA_W'($urandom));
      b = $urandom_range(0, 31);
      l = $urandom_range(0, ($urandom_range(0, 3) == 0) ? 40 : 12);
      m = $urandom_range(0, 2);
      run_burst(b, l, m, 1'b0, 0, '0);
    end

    // abort a burst with reset while its third word is on the output
    @(negedge CLK);
    DO_READY = 1'b1; START = 1'b1; BASE = 5'd5; LEN = 6'd10;
    @(posedge CLK);
    #1;
    START = 1'b0;
    n = 0;
    for (int c = 0; c < 40 && n < 2; c++) begin
      @(negedge CLK);
      if (DO_VALID) n++;
    end
    @(negedge CLK);
    check_eq("third_valid", DO_VALID, 1);
    check_eq("third_word", DO, mem_model[7]);
    #2 RST_N = 1'b0;
    #1;
    check_eq("arst_valid", DO_VALID, 0);
    check_eq("arst_busy", BUSY, 0);
    check_eq("arst_do", DO, 0);
    check_eq("arst_done", DONE, 0);
    @(posedge CLK);
    #3 RST_N = 1'b1;
    run_burst(0, 2, 0, 1'b0, 0, '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire
